// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned ADDR_W = 32;

   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0]   instr;
      logic [ADDR_W-1:0] pc;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch buffer of {instr, pc} entries
// Flush wins over push and pop; DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               push_i,
   input  fetch_entry_t       push_entry_i,
   input  logic               pop_i,
   input  logic               flush_i,
   output fetch_entry_t       head_o,
   output logic [CNT_W-1:0]   count_o,
   output logic               full_o,
   output logic               empty_o
);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !flush_i && !empty_o;
   assign do_push = push_i && !flush_i && (!full_o || do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage needs no reset: the head is only observed while count is non-zero.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetcher feeding a prefetch buffer
// Redirects flush the buffer; a request already in flight is completed and its data dropped.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e     state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      pc_plus4;
   logic [31:0]      redirect_pc_al;
   logic             push;
   logic             pop;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_after;
   logic             fifo_full;
   logic             fifo_empty;

   assign redirect_pc_al = word_align(redirect_pc);
   assign pc_plus4       = fetch_pc_q + 32'd4;

   assign push        = (state_q == REQ) && imem_ack && !redirect;
   assign pop         = !fifo_empty && instr_ready;
   assign push_entry  = '{instr: imem_rdata, pc: addr_q};
   assign count_after = count + CNT_W'(push) - CNT_W'(pop && !redirect);

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i        (clk),
      .rst_ni       (reset),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .flush_i      (redirect),
      .head_o       (head),
      .count_o      (count),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      unique case (state_q)
         IDLE: begin
            if (redirect) begin
               fetch_pc_d = redirect_pc_al;
               addr_d     = redirect_pc_al;
               state_d    = REQ;
            end else if (!fifo_full) begin
               addr_d  = fetch_pc_q;
               state_d = REQ;
            end
         end
         REQ: begin
            if (redirect) begin
               fetch_pc_d = redirect_pc_al;
               if (imem_ack) addr_d  = redirect_pc_al;
               else          state_d = DROP;
            end else if (imem_ack) begin
               fetch_pc_d = pc_plus4;
               if (count_after < CNT_W'(FIFO_DEPTH)) addr_d  = pc_plus4;
               else                                  state_d = IDLE;
            end
         end
         DROP: begin
            // Old address stays on the bus until the stale response arrives.
            if (redirect) fetch_pc_d = redirect_pc_al;
            if (imem_ack) begin
               state_d = REQ;
               addr_d  = redirect ? redirect_pc_al : fetch_pc_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
      end
   end

   assign imem_req    = (state_q != IDLE);
   assign imem_addr   = addr_q;
   assign instr_valid = !fifo_empty;
   assign instr       = instr_valid ? head.instr : 32'd0;
   assign instr_pc    = instr_valid ? head.pc    : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a wait-state memory model
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] XMASK = 32'hA5A5_0000;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] exp_q [$];
   logic [31:0] m_pc;
   logic [31:0] addr_hold;
   logic        hold_valid;
   logic        drop_pend;
   logic        ready_en;
   logic        redir_now;
   logic [31:0] redir_pc_now;
   logic        junk_ack;
   int          wait_cycles;
   int          wcnt;
   int          n_pops;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // One clock: drive inputs at the falling edge, score outputs, then advance.
   task automatic step();
      logic [63:0] e;
      redirect    = redir_now;
      redirect_pc = redir_pc_now;
      instr_ready = ready_en;
      imem_ack    = 1'b0;
      imem_rdata  = 32'd0;
      check("valid", 32'(instr_valid), 32'(exp_q.size() != 0));
      if (!instr_valid) begin
         check("instr_zero", instr, 32'd0);
         check("pc_zero", instr_pc, 32'd0);
      end else if (instr_ready && !redirect && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("instr", instr, e[63:32]);
         check("instr_pc", instr_pc, e[31:0]);
         n_pops++;
      end
      if (imem_req) begin
         if (hold_valid)      check("addr_hold", imem_addr, addr_hold);
         else if (!drop_pend) check("addr", imem_addr, m_pc);
         if (wcnt >= wait_cycles) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr ^ XMASK;
            if (!redirect && !drop_pend) begin
               exp_q.push_back({m_pc ^ XMASK, m_pc});
               m_pc = m_pc + 32'd4;
            end
            drop_pend  = 1'b0;
            hold_valid = 1'b0;
            wcnt       = 0;
         end else begin
            wcnt++;
            if (!hold_valid) addr_hold = imem_addr;
            hold_valid = 1'b1;
            if (redirect) drop_pend = 1'b1;
         end
      end else begin
         wcnt       = 0;
         hold_valid = 1'b0;
         if (junk_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
         end
      end
      if (redirect) begin
         exp_q.delete();
         m_pc = redir_pc_now & ~32'h3;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset        = 1'b0;
      redirect     = 1'b0;
      redirect_pc  = 32'd0;
      imem_ack     = 1'b0;
      imem_rdata   = 32'd0;
      instr_ready  = 1'b0;
      redir_now    = 1'b0;
      redir_pc_now = 32'd0;
      exp_q.delete();
      m_pc       = 32'd0;
      hold_valid = 1'b0;
      drop_pend  = 1'b0;
      wcnt       = 0;
      repeat (3) @(negedge clk);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_pc", instr_pc, 32'd0);
      reset = 1'b1;
      check("idle_after_rel", 32'(imem_req), 32'd0);
      step();
      check("first_req", 32'(imem_req), 32'd1);
   endtask

   initial begin
      reset       = 1'b0;
      wait_cycles = 0;
      ready_en    = 1'b1;
      junk_ack    = 1'b0;
      n_pops      = 0;

      // Zero-wait streaming: one instruction per cycle, pc 0,4,8,...
      do_reset();
      step();
      n_pops = 0;
      repeat (10) step();
      check("throughput", 32'(n_pops), 32'd10);

      // Stalled consumer fills the buffer, then fetch resumes at 0x10
      ready_en = 1'b0;
      do_reset();
      repeat (8) step();
      check("full_req", 32'(imem_req), 32'd0);
      check("full_cnt", 32'(exp_q.size()), 32'd4);
      ready_en = 1'b1;
      for (int i = 0; i < 10 && !imem_req; i++) step();
      check("resume_addr", imem_addr, 32'h10);
      repeat (6) step();

      // Redirect during the second wait cycle of a 3-wait access
      wait_cycles = 3;
      do_reset();
      step();
      redir_now    = 1'b1;
      redir_pc_now = 32'h100;
      step();
      redir_now = 1'b0;
      for (int i = 0; i < 30 && !instr_valid; i++) step();
      check("redir_first_pc", instr_pc, 32'h100);
      repeat (8) step();

      // Redirect coincident with ack, unaligned target
      wait_cycles = 0;
      do_reset();
      redir_now    = 1'b1;
      redir_pc_now = 32'h203;
      step();
      redir_now = 1'b0;
      check("rd_ack_addr", imem_addr, 32'h200);
      check("rd_ack_valid", 32'(instr_valid), 32'd0);
      repeat (4) step();

      // Address wrap at the top of the address space
      redir_now    = 1'b1;
      redir_pc_now = 32'hFFFF_FFF8;
      step();
      redir_now = 1'b0;
      check("wrap0", imem_addr, 32'hFFFF_FFF8);
      step();
      check("wrap1", imem_addr, 32'hFFFF_FFFC);
      step();
      check("wrap2", imem_addr, 32'h0000_0000);
      repeat (3) step();

      // Asynchronous reset mid-request with two entries buffered
      wait_cycles = 1;
      ready_en    = 1'b0;
      do_reset();
      for (int i = 0; i < 20 && !(exp_q.size() == 2 && imem_req); i++) step();
      check("pre_rst_valid", 32'(instr_valid), 32'd1);
      check("pre_rst_req", 32'(imem_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_req", 32'(imem_req), 32'd0);
      check("async_addr", imem_addr, 32'd0);
      check("async_valid", 32'(instr_valid), 32'd0);
      check("async_instr", instr, 32'd0);
      check("async_pc", instr_pc, 32'd0);
      junk_ack = 1'b1;
      ready_en = 1'b1;
      do_reset();
      repeat (8) step();
      junk_ack = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line:
  RESET_PC, 32'h0000_0000, first fetch address after reset
  FIFO_DEPTH, 4, prefetch buffer entries (power of two, >=2)
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock, all state on rising edge
  reset  input  1  asynchronous, active-low reset
  redirect  input  1  one-cycle pulse: flush and restart fetch at redirect_pc
  redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 0
  imem_req  output  1  instruction-memory request
  imem_addr  output  32  word-aligned request address
  imem_ack  input  1  memory completes request this cycle; imem_rdata valid
  imem_rdata  input  32  instruction word returned with imem_ack
  instr_valid  output  1  head of prefetch buffer is valid
  instr  output  32  head instruction word; 0 when instr_valid=0
  instr_pc  output  32  address of head instruction; 0 when instr_valid=0
  instr_ready  input  1  consumer accepts head this cycle

Function
REQ-003 The FSM SHALL have states IDLE, REQ and DROP; imem_req SHALL be 1 exactly in REQ and DROP, driven from registered state.
REQ-004 Memory handshake: while imem_req=1, imem_addr SHALL be held stable until a cycle with imem_ack=1; imem_ack SHALL be ignored while imem_req=0; at most one request SHALL be outstanding.
REQ-005 IDLE->REQ SHALL occur when the buffer holds fewer than FIFO_DEPTH entries and redirect=0; imem_addr SHALL equal fetch_pc.
REQ-006 In REQ with imem_ack=1 and redirect=0: push {imem_rdata, imem_addr}; fetch_pc += 4; stay REQ when entries after this cycle < FIFO_DEPTH, else go to IDLE.
REQ-007 fetch_pc arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-008 A pop SHALL occur when instr_valid=1 and instr_ready=1; a push and a pop in the same cycle SHALL leave the entry count unchanged.
REQ-009 A push SHALL never be attempted when the buffer is full; this follows from REQ-006.
REQ-010 On redirect=1, all of the following SHALL occur in that cycle:
  - the buffer is flushed (instr_valid=0 next cycle); any pop that cycle is ignored
  - fetch_pc <= {redirect_pc[31:2], 2'b00}
REQ-011 Redirect in REQ without imem_ack SHALL move to DROP; in DROP the old address SHALL be held until imem_ack, the returned data SHALL be discarded, and the FSM SHALL go to REQ at the new fetch_pc.
REQ-012 Redirect in the same cycle as imem_ack SHALL discard that data; the next state SHALL be REQ at the new fetch_pc.
REQ-013 Redirect in IDLE SHALL go to REQ next cycle at the new fetch_pc; a redirect in DROP SHALL update fetch_pc and remain in DROP.
REQ-014 Latency: the first instruction SHALL appear on instr_valid in the cycle after its imem_ack.
REQ-015 Sustained throughput with zero-wait memory (ack in the first req cycle) and instr_ready=1 SHALL be one instruction per cycle.

Reset
REQ-016 reset=0 SHALL asynchronously force: state IDLE, fetch_pc=RESET_PC, buffer empty, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-017 Reset asserted mid-request SHALL abandon the request; no memory response after release SHALL be accepted until a new request is issued.
REQ-018 The first request SHALL be issued in the second cycle after reset release (IDLE->REQ).

Structure
REQ-019 Package fetch_pkg SHALL hold the FSM state enumeration, instruction/address width constants (32) and the default RESET_PC.
REQ-020 The buffer SHALL be a sub-module fetch_fifo: synchronous FIFO of {instr, pc} entries with push, pop, flush, count, full and empty; flush SHALL have priority over push and pop.

Verification
REQ-021 Reset release with RESET_PC=0 and zero-wait memory returning addr^32'hA5A5_0000 -> imem_addr sequence 0,4,8,...; instr_pc 0,4,8 on consecutive cycles.
REQ-022 instr_ready=0, ack always 1 -> exactly 4 entries buffered, imem_req drops to 0; instr_ready=1 -> fetch resumes at 0x10.
REQ-023 Memory with 3-cycle wait, redirect to 0x100 in the second wait cycle -> old data discarded, next imem_addr=0x100, first instr_pc=0x100.
REQ-024 Redirect and imem_ack in the same cycle, redirect_pc=0x203 -> data dropped, next imem_addr=0x200.
REQ-025 fetch_pc=0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-026 Reset asserted while imem_req=1 and 2 entries buffered -> all outputs at REQ-016 values immediately, before the next clock edge.
